// File: rtl/calc_key_sequencer_pkg.sv
// Scan-code constants, state/key encodings and the display field bundle
// shared by the keypad calculator sequencer and its prefix filter.
package calc_pkg;

   localparam logic [7:0] SC_F0    = 8'hF0;
   localparam logic [7:0] SC_E0    = 8'hE0;
   localparam logic [7:0] SC_PLUS  = 8'h79;
   localparam logic [7:0] SC_MINUS = 8'h7B;
   localparam logic [7:0] SC_MUL   = 8'h7C;
   localparam logic [7:0] SC_EQ    = 8'h55;
   localparam logic [7:0] SC_ESC   = 8'h76;

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MUL = 2'd2;

   localparam logic [3:0] NO_DIGIT = 4'hF;

   typedef enum logic [2:0] {
      S_A,
      S_OP,
      S_B,
      S_EQ,
      S_RES
   } state_t;

   typedef enum logic [2:0] {
      K_NONE,
      K_DIGIT,
      K_OP,
      K_EQ,
      K_ESC
   } key_t;

   typedef struct packed {
      logic [3:0] opa;
      logic [3:0] opb;
      logic [1:0] op;
      logic       a_vld;
      logic       op_vld;
      logic       b_vld;
      logic [6:0] res_mag;
      logic       res_neg;
      logic       res_vld;
   } fields_t;

   // Keypad digit scan codes are not contiguous; anything else maps to NO_DIGIT.
   function automatic logic [3:0] scan_to_digit(input logic [7:0] code);
      case (code)
         8'h70:   return 4'd0;
         8'h69:   return 4'd1;
         8'h72:   return 4'd2;
         8'h7A:   return 4'd3;
         8'h6B:   return 4'd4;
         8'h73:   return 4'd5;
         8'h74:   return 4'd6;
         8'h6C:   return 4'd7;
         8'h75:   return 4'd8;
         8'h7D:   return 4'd9;
         default: return NO_DIGIT;
      endcase
   endfunction

endpackage

// File: rtl/calc_key_sequencer_make_filter.sv
// PS/2 prefix filter: drops E0 prefixes and whole F0 break pairs, and
// forwards every remaining byte as a registered one-cycle make strobe.
module ps2_make_filter
   import calc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   output logic       make_stb,
   output logic [7:0] make_code
);

   logic brk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         brk       <= 1'b0;
         make_stb  <= 1'b0;
         make_code <= 8'h00;
      end else begin
         make_stb <= 1'b0;
         if (scan_valid) begin
            if (scan_code == SC_F0) begin
               brk <= 1'b1;
            end else if (scan_code == SC_E0) begin
               brk <= brk;
            end else if (brk) begin
               brk <= 1'b0;
            end else begin
               make_stb  <= 1'b1;
               make_code <= scan_code;
            end
         end
      end
   end

endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad calculator sequencer: A, operator, B, '=' with single-digit operands.
// Define CALC_MUL_EN to accept keypad '*' (7C) as a multiply operator.
module calc_key_sequencer
   import calc_pkg::*;
#(
   parameter int TIMEOUT = 50_000_000,
   parameter int TO_W    = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] scan_code,
   input  logic       scan_valid,
   output logic [3:0] opa,
   output logic [3:0] opb,
   output logic [1:0] op,
   output logic       a_vld,
   output logic       op_vld,
   output logic       b_vld,
   output logic [6:0] res_mag,
   output logic       res_neg,
   output logic       res_vld,
   output logic       err
);

   logic            make_stb;
   logic [7:0]      make_code;
   state_t          state_q, state_d;
   fields_t         f_q, f_d;
   logic            err_q, err_d;
   logic [TO_W-1:0] to_cnt;
   logic            to_expire;
   key_t            key;
   logic [3:0]      key_digit;
   logic [1:0]      key_op;
   logic signed [4:0] diff;
   logic [6:0]      calc_mag;
   logic            calc_neg;

   ps2_make_filter u_filter (
      .clk        (clk),
      .reset      (reset),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .make_stb   (make_stb),
      .make_code  (make_code)
   );

   always_comb begin
      key_digit = scan_to_digit(make_code);
      key_op    = OP_ADD;
      key       = K_NONE;
      if (key_digit != NO_DIGIT) begin
         key = K_DIGIT;
      end else if (make_code == SC_PLUS) begin
         key = K_OP;
      end else if (make_code == SC_MINUS) begin
         key    = K_OP;
         key_op = OP_SUB;
`ifdef CALC_MUL_EN
      end else if (make_code == SC_MUL) begin
         key    = K_OP;
         key_op = OP_MUL;
`endif
      end else if (make_code == SC_EQ) begin
         key = K_EQ;
      end else if (make_code == SC_ESC) begin
         key = K_ESC;
      end
   end

   // Result from the latched operands; subtraction goes through 5-bit signed.
   always_comb begin
      diff     = $signed({1'b0, f_q.opa}) - $signed({1'b0, f_q.opb});
      calc_neg = 1'b0;
      calc_mag = {3'b000, f_q.opa} + {3'b000, f_q.opb};
      if (f_q.op == OP_SUB) begin
         calc_neg = diff[4];
         calc_mag = {2'b00, (diff[4] ? -diff : diff)};
      end
`ifdef CALC_MUL_EN
      else if (f_q.op == OP_MUL) begin
         calc_mag = {3'b000, f_q.opa} * {3'b000, f_q.opb};
      end
`endif
   end

   // A make strobe in the expiry cycle suppresses the auto-clear.
   assign to_expire = (TIMEOUT != 0) && (state_q != S_A) && !make_stb &&
                      (to_cnt == TO_W'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt <= '0;
      end else if ((TIMEOUT == 0) || make_stb || (state_q == S_A) || to_expire) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_A;
         f_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (to_expire) begin
         state_d = S_A;
      end else if (make_stb) begin
         case (key)
            K_ESC:   state_d = S_A;
            K_DIGIT: begin
               case (state_q)
                  S_A:     state_d = S_OP;
                  S_B:     state_d = S_EQ;
                  S_RES:   state_d = S_OP;
                  default: state_d = state_q;
               endcase
            end
            K_OP:    if (state_q == S_OP) state_d = S_B;
            K_EQ:    if (state_q == S_EQ) state_d = S_RES;
            default: state_d = state_q;
         endcase
      end
   end

   // Illegal keys raise err and leave every field as it was.
   always_comb begin
      f_d   = f_q;
      err_d = 1'b0;
      if (to_expire) begin
         f_d = '0;
      end else if (make_stb) begin
         case (key)
            K_ESC: f_d = '0;
            K_DIGIT: begin
               case (state_q)
                  S_A: begin
                     f_d.opa   = key_digit;
                     f_d.a_vld = 1'b1;
                  end
                  S_OP: f_d.opa = key_digit;
                  S_B: begin
                     f_d.opb   = key_digit;
                     f_d.b_vld = 1'b1;
                  end
                  S_EQ: f_d.opb = key_digit;
                  default: begin
                     f_d.opa     = key_digit;
                     f_d.op_vld  = 1'b0;
                     f_d.b_vld   = 1'b0;
                     f_d.res_vld = 1'b0;
                  end
               endcase
            end
            K_OP: begin
               if (state_q == S_OP) begin
                  f_d.op     = key_op;
                  f_d.op_vld = 1'b1;
               end else if (state_q == S_B) begin
                  f_d.op = key_op;
               end else begin
                  err_d = 1'b1;
               end
            end
            K_EQ: begin
               if (state_q == S_EQ) begin
                  f_d.res_mag = calc_mag;
                  f_d.res_neg = calc_neg;
                  f_d.res_vld = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            default: f_d = f_q;
         endcase
      end
   end

   assign opa     = f_q.opa;
   assign opb     = f_q.opb;
   assign op      = f_q.op;
   assign a_vld   = f_q.a_vld;
   assign op_vld  = f_q.op_vld;
   assign b_vld   = f_q.b_vld;
   assign res_mag = f_q.res_mag;
   assign res_neg = f_q.res_neg;
   assign res_vld = f_q.res_vld;
   assign err     = err_q;

endmodule
